// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader and its byte packer.
package boot_loader_pkg;

    localparam int BOOT_HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } boot_state_t;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Assembles four little-endian bytes into a word; word_valid pulses combinationally
// with the fourth byte so the caller can register the full word on that same edge.
module boot_loader_byte_packer
    import boot_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [7:0]                  byte_in,
    input  logic                        byte_valid,
    output logic [8*BOOT_HDR_BYTES-1:0] word,
    output logic                        word_valid
);

    localparam int CNT_W = $clog2(BOOT_HDR_BYTES);

    logic [CNT_W-1:0] cnt_reg;

    // Counter wraps naturally after the last byte, ready for the next word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (byte_valid) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < BOOT_HDR_BYTES - 1; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    lane_reg <= '0;
                end else if (byte_valid && cnt_reg == CNT_W'(gi)) begin
                    lane_reg <= byte_in;
                end
            end

            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

    // Top byte bypasses storage: it is the byte arriving now.
    assign word[8*BOOT_HDR_BYTES-1 -: 8] = byte_in;
    assign word_valid = byte_valid && (cnt_reg == CNT_W'(BOOT_HDR_BYTES - 1));

endmodule

// File: rtl/boot_loader.sv
// Receives a length-prefixed little-endian program image, writes it into core
// memory one word at a time, and releases the core after a fixed hold interval.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_WORDS  = 512,
    parameter int RESET_HOLD = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic             load_req,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             core_rst,
    output logic             done,
    output logic             error
);

    localparam int WORD_W = 8 * BOOT_HDR_BYTES;
    localparam int IDX_W  = $clog2(MAX_WORDS + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    boot_state_t       state_reg, state_next;
    logic [IDX_W-1:0]  index_reg, index_next;
    logic [IDX_W-1:0]  last_idx_reg, last_idx_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [WIDTH-1:0]  flash_addr_reg, flash_addr_next;
    logic [WIDTH-1:0]  flash_data_reg, flash_data_next;
    logic              flash_en_reg, flash_en_next;
    logic              core_rst_reg, core_rst_next;
    logic              done_reg, done_next;
    logic              error_reg, error_next;

    logic              byte_accept;
    logic              restart;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              hdr_zero;
    logic              hdr_too_big;
    logic              hold_expired;

    assign rx_ready     = !rst && (state_reg == ST_HDR || state_reg == ST_DATA);
    assign byte_accept  = rx_valid && rx_ready;
    assign restart      = load_req && (state_reg == ST_RUN || state_reg == ST_ERR);
    assign hdr_zero     = (word == '0);
    assign hdr_too_big  = (word > WORD_W'(MAX_WORDS));
    assign hold_expired = (hold_cnt_reg == HOLD_LAST);

    boot_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart),
        .byte_in    (rx_data),
        .byte_valid (byte_accept),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_HDR;
            index_reg      <= '0;
            last_idx_reg   <= '0;
            hold_cnt_reg   <= '0;
            flash_addr_reg <= '0;
            flash_data_reg <= '0;
            flash_en_reg   <= 1'b0;
            core_rst_reg   <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            last_idx_reg   <= last_idx_next;
            hold_cnt_reg   <= hold_cnt_next;
            flash_addr_reg <= flash_addr_next;
            flash_data_reg <= flash_data_next;
            flash_en_reg   <= flash_en_next;
            core_rst_reg   <= core_rst_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_HDR: begin
                if (word_valid) begin
                    if (hdr_zero)         state_next = ST_HOLD;
                    else if (hdr_too_big) state_next = ST_ERR;
                    else                  state_next = ST_DATA;
                end
            end
            ST_DATA:  if (word_valid) state_next = ST_WRITE;
            ST_WRITE: state_next = (index_reg == last_idx_reg) ? ST_HOLD : ST_DATA;
            ST_HOLD:  if (hold_expired) state_next = ST_RUN;
            ST_RUN:   if (load_req) state_next = ST_HDR;
            ST_ERR:   if (load_req) state_next = ST_HDR;
            default:  state_next = ST_HDR;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        index_next      = index_reg;
        last_idx_next   = last_idx_reg;
        hold_cnt_next   = hold_cnt_reg;
        flash_addr_next = flash_addr_reg;
        flash_data_next = flash_data_reg;
        flash_en_next   = 1'b0;
        core_rst_next   = core_rst_reg;
        done_next       = done_reg;
        error_next      = error_reg;
        case (state_reg)
            ST_HDR: begin
                if (word_valid) begin
                    last_idx_next = word[IDX_W-1:0] - IDX_W'(1);
                    index_next    = '0;
                    hold_cnt_next = '0;
                    error_next    = hdr_too_big;
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    flash_en_next   = 1'b1;
                    flash_addr_next = WIDTH'({index_reg, 2'b00});
                    flash_data_next = WIDTH'(word);
                end
            end
            ST_WRITE: begin
                index_next    = index_reg + 1'b1;
                hold_cnt_next = '0;
            end
            ST_HOLD: begin
                if (hold_expired) begin
                    core_rst_next = 1'b0;
                    done_next     = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (load_req) begin
                    core_rst_next = 1'b1;
                    done_next     = 1'b0;
                    index_next    = '0;
                    hold_cnt_next = '0;
                end
            end
            ST_ERR: begin
                if (load_req) error_next = 1'b0;
            end
            default: begin
                core_rst_next = 1'b1;
            end
        endcase
    end

    assign flash_addr = flash_addr_reg;
    assign flash_data = flash_data_reg;
    assign flash_en   = flash_en_reg;
    assign core_rst   = core_rst_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule
